gpio_controller_intr_sched: RTL and testbench

GPIO_CONTROLLER_INTR_SCHED -- requirements
Module: gpio_controller_intr_sched

---
 rtl/gpio_controller_intr_sched_if.sv | 19 +
 rtl/gpio_controller_intr_sched.sv | 129 ++++++++++++
 tb/tb_gpio_controller_intr_sched.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_controller_intr_sched_if.sv
// Interrupt message channel: valid/ready handshake carrying a 4-bit source id.
// master: drives intr_msg_valid, intr_msg_id; slave: drives intr_msg_ready.
interface gpio_controller_intr_sched_if;
    logic       intr_msg_valid;
    logic       intr_msg_ready;
    logic [3:0] intr_msg_id;

    modport master (
        output intr_msg_valid,
        output intr_msg_id,
        input  intr_msg_ready
    );

    modport slave (
        input  intr_msg_valid,
        input  intr_msg_id,
        output intr_msg_ready
    );
endinterface

// File: rtl/gpio_controller_intr_sched.sv
// GPIO interrupt scheduler: sticky pending bits, round-robin message issue with holdoff.
// Ports: clk, rst_n, edge set pulses, msg_enable, W1C clear, intr_status, intr_irq, msg (master).
module gpio_controller_intr_sched #(
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  posedge_intr_status_set,
    input  logic [7:0]  negedge_intr_status_set,
    input  logic [15:0] msg_enable,
    input  logic        status_clear_valid,
    input  logic [15:0] status_clear_mask,
    output logic [15:0] intr_status,
    output logic        intr_irq,
    gpio_controller_intr_sched_if.master msg
);

    localparam int CW = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     pending_q, pending_d;
    logic [15:0]     notified_q, notified_d;
    logic [3:0]      id_q, id_d;
    logic [3:0]      last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            irq_q, irq_d;

    logic [15:0]     set_vec;
    logic [15:0]     clr_vec;
    logic [15:0]     hs_vec;
    logic [15:0]     eligible;
    logic            hs;
    logic            win_found;
    logic [3:0]      win_id;

    assign set_vec  = {negedge_intr_status_set, posedge_intr_status_set};
    assign clr_vec  = status_clear_valid ? status_clear_mask : 16'h0000;
    assign hs       = (state_q == SEND) && msg.intr_msg_ready;
    assign hs_vec   = hs ? (16'h0001 << id_q) : 16'h0000;
    assign eligible = pending_q & ~notified_q & msg_enable;

    // A set in the same cycle as a clear is a fresh event, so it wipes
    // notified; a handshake on an already-cleared id records nothing.
    always_comb begin
        pending_d  = (pending_q & ~clr_vec) | set_vec;
        notified_d = pending_d & ~(set_vec & clr_vec) & (notified_q | hs_vec);
        irq_d      = |(pending_q & msg_enable);
    end

    // Round-robin: k=16 wraps to last_grant itself, so it is searched last.
    always_comb begin
        win_found = 1'b0;
        win_id    = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            if (!win_found && eligible[last_grant_q + 4'(k)]) begin
                win_found = 1'b1;
                win_id    = last_grant_q + 4'(k);
            end
        end
    end

    // Leaving HOLDOFF when the counter reaches 1 makes the following IDLE
    // cycle the last of the HOLDOFF_CYCLES gap cycles.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (win_found) begin
                    id_d    = win_id;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    last_grant_d = id_q;
                    if (HOLDOFF_CYCLES > 1) begin
                        state_d = HOLDOFF;
                        cnt_d   = CW'(HOLDOFF_CYCLES);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(2)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            notified_q   <= '0;
            id_q         <= '0;
            last_grant_q <= 4'd15;
            cnt_q        <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            notified_q   <= notified_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            irq_q        <= irq_d;
        end
    end

    assign intr_status        = pending_q;
    assign intr_irq           = irq_q;
    assign msg.intr_msg_valid = (state_q == SEND);
    assign msg.intr_msg_id    = id_q;

endmodule

// File: tb/tb_gpio_controller_intr_sched.sv
// Testbench for gpio_controller_intr_sched: table-driven vectors plus
// hand-written stall, in-flight clear and mid-SEND reset sequences.
module tb_gpio_controller_intr_sched;

    localparam int HO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pos;
    logic [7:0]  neg;
    logic [15:0] en;
    logic        clr;
    logic [15:0] mask;
    logic [15:0] st;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpio_controller_intr_sched_if bus();

    gpio_controller_intr_sched #(.HOLDOFF_CYCLES(HO)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .posedge_intr_status_set (pos),
        .negedge_intr_status_set (neg),
        .msg_enable              (en),
        .status_clear_valid      (clr),
        .status_clear_mask       (mask),
        .intr_status             (st),
        .intr_irq                (irq),
        .msg                     (bus.master)
    );

    typedef struct {
        logic [7:0]  pos;
        logic [7:0]  neg;
        logic [15:0] en;
        logic        clr;
        logic [15:0] mask;
        logic        rdy;
        logic [15:0] st;
        logic        vld;
        logic [3:0]  id;
        logic        irq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] p, input logic [7:0] n,
                       input logic [15:0] e, input logic c,
                       input logic [15:0] m, input logic r,
                       input logic [15:0] s, input logic v,
                       input logic [3:0] i, input logic q);
        vec_t t;
        t.pos = p; t.neg = n; t.en = e; t.clr = c; t.mask = m;
        t.rdy = r; t.st = s; t.vld = v; t.id = i; t.irq = q;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        pos = 8'h00;
        neg = 8'h00;
        clr = 1'b0;
        mask = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_in();
        en = 16'hFFFF;
        bus.intr_msg_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        idle_in();
        en = 16'hFFFF;
        bus.intr_msg_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst st", 32'(st), 32'h0);
        chk("rst vld", 32'(bus.intr_msg_valid), 32'h0);
        chk("rst id", 32'(bus.intr_msg_id), 32'h0);
        chk("rst irq", 32'(irq), 32'h0);

        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ordering 0, 2, 8 with four-cycle gaps
        add(8'h05, 8'h01, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd0, 0);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 1, 4'd0, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd0, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd0, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd0, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd0, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 1, 4'd2, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd2, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd2, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd2, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd2, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 1, 4'd8, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd8, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd8, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd8, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd8, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0105, 0, 4'd8, 1);
        // Clear everything; irq follows one cycle later
        add(8'h00, 8'h00, 16'hFFFF, 1, 16'hFFFF, 1, 16'h0000, 0, 4'd8, 1);
        add(8'h00, 8'h00, 16'hFFFF, 0, 16'h0, 1, 16'h0000, 0, 4'd8, 0);
        // Pending with all messages disabled, then enable id 4
        add(8'hFF, 8'h00, 16'h0000, 0, 16'h0, 1, 16'h00FF, 0, 4'd8, 0);
        add(8'h00, 8'h00, 16'h0000, 0, 16'h0, 1, 16'h00FF, 0, 4'd8, 0);
        add(8'h00, 8'h00, 16'h0000, 0, 16'h0, 1, 16'h00FF, 0, 4'd8, 0);
        add(8'h00, 8'h00, 16'h0010, 0, 16'h0, 1, 16'h00FF, 1, 4'd4, 1);
        add(8'h00, 8'h00, 16'h0010, 0, 16'h0, 1, 16'h00FF, 0, 4'd4, 1);
        add(8'h00, 8'h00, 16'h0010, 0, 16'h0, 1, 16'h00FF, 0, 4'd4, 1);
        add(8'h00, 8'h00, 16'h0010, 0, 16'h0, 1, 16'h00FF, 0, 4'd4, 1);
        add(8'h00, 8'h00, 16'h0010, 0, 16'h0, 1, 16'h00FF, 0, 4'd4, 1);
        // Simultaneous set + clear of notified id 4 re-arms it
        add(8'h10, 8'h00, 16'h0010, 1, 16'h0010, 1, 16'h00FF, 0, 4'd4, 1);
        add(8'h00, 8'h00, 16'h0010, 0, 16'h0, 1, 16'h00FF, 1, 4'd4, 1);
        add(8'h00, 8'h00, 16'h0010, 0, 16'h0, 0, 16'h00FF, 1, 4'd4, 1);
        add(8'h00, 8'h00, 16'h0010, 0, 16'h0, 1, 16'h00FF, 0, 4'd4, 1);
        // Plain re-set without clear: no further message
        add(8'h10, 8'h00, 16'h0010, 0, 16'h0, 1, 16'h00FF, 0, 4'd4, 1);
        add(8'h00, 8'h00, 16'h0010, 0, 16'h0, 1, 16'h00FF, 0, 4'd4, 1);
        add(8'h00, 8'h00, 16'h0010, 0, 16'h0, 1, 16'h00FF, 0, 4'd4, 1);
        add(8'h00, 8'h00, 16'h0010, 0, 16'h0, 1, 16'h00FF, 0, 4'd4, 1);
        add(8'h00, 8'h00, 16'h0010, 0, 16'h0, 1, 16'h00FF, 0, 4'd4, 1);

        foreach (tbl[i]) begin
            pos  = tbl[i].pos;
            neg  = tbl[i].neg;
            en   = tbl[i].en;
            clr  = tbl[i].clr;
            mask = tbl[i].mask;
            bus.intr_msg_ready = tbl[i].rdy;
            tick();
            chk($sformatf("row%0d st", i), 32'(st), 32'(tbl[i].st));
            chk($sformatf("row%0d vld", i), 32'(bus.intr_msg_valid),
                32'(tbl[i].vld));
            chk($sformatf("row%0d id", i), 32'(bus.intr_msg_id),
                32'(tbl[i].id));
            chk($sformatf("row%0d irq", i), 32'(irq), 32'(tbl[i].irq));
        end

        // Long stall on id 3, with its pending bit cleared mid-stall
        do_reset();
        bus.intr_msg_ready = 1'b0;
        pos = 8'h08;
        tick();
        idle_in();
        chk("stall st", 32'(st), 32'h0008);
        tick();
        chk("stall start", 32'({bus.intr_msg_valid, bus.intr_msg_id}),
            32'h13);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                clr = 1'b1;
                mask = 16'h0008;
            end else begin
                clr = 1'b0;
                mask = 16'h0000;
            end
            tick();
            chk($sformatf("stall c%0d", i),
                32'({bus.intr_msg_valid, bus.intr_msg_id}), 32'h13);
        end
        chk("stall clr st", 32'(st), 32'h0000);
        bus.intr_msg_ready = 1'b1;
        tick();
        chk("stall hs", 32'(bus.intr_msg_valid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("stall quiet%0d", i), 32'(bus.intr_msg_valid),
                32'h0);
        end

        // Reset asserted while a message is in flight
        pos = 8'h02;
        tick();
        idle_in();
        tick();
        chk("rs send", 32'({bus.intr_msg_valid, bus.intr_msg_id}), 32'h11);
        bus.intr_msg_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs async vld", 32'(bus.intr_msg_valid), 32'h0);
        chk("rs async st", 32'(st), 32'h0);
        chk("rs async id", 32'(bus.intr_msg_id), 32'h0);
        chk("rs async irq", 32'(irq), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.intr_msg_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rs quiet%0d", i),
                32'({st, 3'b000, bus.intr_msg_valid, irq}), 32'h0);
        end

        // Latency from a fresh pulse, id 0 first after reset
        pos = 8'h01;
        tick();
        idle_in();
        chk("lat st", 32'(st), 32'h0001);
        chk("lat vld0", 32'(bus.intr_msg_valid), 32'h0);
        tick();
        chk("lat msg", 32'({bus.intr_msg_valid, bus.intr_msg_id}), 32'h10);
        for (int i = 0; i < HO + 2; i++) begin
            tick();
            chk($sformatf("lat gap%0d", i), 32'(bus.intr_msg_valid), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_err);
        $finish;
    end

endmodule
